ir_queue: RTL and testbench

//  Parametrised instruction-register successor: a DEPTH-entry prefetch queue of instruction words with

---
 rtl/ir_pkg.sv | 39 +++
 rtl/ir_field_decode.sv | 27 ++
 rtl/ir_queue.sv | 126 ++++++++++++
 tb/tb_ir_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Package for the instruction-register queue.
// Holds the default instruction/opcode widths, the bit positions of every
// decoded field, and the decoded-field struct shared by ir_field_decode and
// ir_queue.
// The field struct is sized from IR_IW/IR_OPW. If ir_queue is instantiated
// with a different IW/OPW, these two localparams must be changed to match.
package ir_pkg;

  localparam int IR_IW  = 16;
  localparam int IR_OPW = 6;

  // Position helpers. Fields are laid out from the MSB down.
  function automatic int op_msb(input int iw);
    return iw - 1;
  endfunction

  function automatic int ra_bit(input int iw, input int opw);
    return iw - opw - 1;
  endfunction

  function automatic int imm_msb(input int iw, input int opw);
    return iw - opw - 2;
  endfunction

  localparam int OP_MSB    = op_msb(IR_IW);
  localparam int RA_BIT    = ra_bit(IR_IW, IR_OPW);
  localparam int RASTK_MSB = ra_bit(IR_IW, IR_OPW);
  localparam int BA_MSB    = ra_bit(IR_IW, IR_OPW);
  localparam int IMM_MSB   = imm_msb(IR_IW, IR_OPW);

  typedef struct packed {
    logic [IR_OPW-1:0] opcode;
    logic              ra;
    logic [1:0]        ra_stack;
    logic [BA_MSB:0]   ba;
    logic [IMM_MSB:0]  imm;
  } ir_fields_t;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of an instruction word into its decoded fields.
// All fields are forced to zero when the word is not valid, so that the
// consumer never sees stale data.
// Ports:
//   word_i   instruction word
//   valid_i  word is valid
//   fields_o decoded fields (opcode, RA, RA_stack, BA, IMM)
module ir_field_decode
  import ir_pkg::*;
(
  input  logic [IR_IW-1:0] word_i,
  input  logic             valid_i,
  output ir_fields_t       fields_o
);

  always_comb begin
    fields_o = '0;
    if (valid_i) begin
      fields_o.opcode   = word_i[OP_MSB -: IR_OPW];
      fields_o.ra       = word_i[RA_BIT];
      fields_o.ra_stack = word_i[RASTK_MSB -: 2];
      fields_o.ba       = word_i[BA_MSB:0];
      fields_o.imm      = word_i[IMM_MSB:0];
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction prefetch queue with head-field decode.
// DEPTH-entry FIFO between instruction fetch and the control unit, with
// valid/ready handshakes on both sides. The head entry is decoded
// combinationally into opcode/RA/RA_stack/BA/IMM.
// Optional feature macro: IR_QUEUE_BYPASS_EN - when the queue is empty, an
// offered word is presented on the outputs in the same cycle and, if
// consumed, is never written into storage.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   flush               discard all queued entries
//   in_valid/in/in_ready  fetch side handshake and word
//   out_valid/out_ready/out  control-unit side handshake and head word
//   opcode, RA, RA_stack, BA, IMM  decoded fields of the head word
//   count               current occupancy
module ir_queue
  import ir_pkg::*;
#(
  parameter int IW    = IR_IW,
  parameter int OPW   = IR_OPW,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [IW-1:0]     in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     out,
  output logic [OPW-1:0]    opcode,
  output logic              RA,
  output logic [1:0]        RA_stack,
  output logic [IW-OPW-1:0] BA,
  output logic [IW-OPW-2:0] IMM,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          head_valid;
  logic          sel_valid;
  logic [IW-1:0] sel_word;
  logic          push, pop;
  logic          wr_en, rd_en;
  ir_fields_t    fields;

  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready;

`ifdef IR_QUEUE_BYPASS_EN
  logic bypass;
  // Empty queue: the offered word is the head this cycle. A word consumed
  // here never touches storage.
  assign bypass    = ~head_valid & in_valid & ~flush;
  assign sel_valid = head_valid | bypass;
  assign sel_word  = bypass ? in : mem_q[rd_ptr_q];
  assign pop       = sel_valid & out_ready;
  assign wr_en     = push & ~flush & ~(bypass & out_ready);
  assign rd_en     = pop & ~flush & ~bypass;
`else
  assign sel_valid = head_valid;
  assign sel_word  = mem_q[rd_ptr_q];
  assign pop       = sel_valid & out_ready;
  assign wr_en     = push & ~flush;
  assign rd_en     = pop & ~flush;
`endif

  assign out_valid = sel_valid;
  assign out       = sel_valid ? sel_word : '0;
  assign count     = count_q;

  ir_field_decode u_decode (
    .word_i   (sel_word),
    .valid_i  (sel_valid),
    .fields_o (fields)
  );

  assign opcode   = fields.opcode;
  assign RA       = fields.ra;
  assign RA_stack = fields.ra_stack;
  assign BA       = fields.ba;
  assign IMM      = fields.imm;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= in;
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue (default parameters IW=16, OPW=6, DEPTH=4).
// A word-level queue model predicts occupancy, handshakes, head word and
// decoded fields every cycle; directed scenarios plus random traffic.
module tb_ir_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_w;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_w;
  logic [5:0]  opcode;
  logic        ra;
  logic [1:0]  ra_stack;
  logic [9:0]  ba;
  logic [8:0]  imm;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model_q[$];
  logic        exp_ov;
  logic [15:0] exp_out;
  logic        exp_byp;

  ir_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in        (in_w),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .opcode    (opcode),
    .RA        (ra),
    .RA_stack  (ra_stack),
    .BA        (ba),
    .IMM       (imm),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for the current inputs, from the word-level model.
  task automatic check_outputs();
    exp_byp = 1'b0;
`ifdef IR_QUEUE_BYPASS_EN
    exp_byp = (model_q.size() == 0) && in_valid && !flush;
`endif
    exp_ov  = (model_q.size() != 0) || exp_byp;
    exp_out = exp_byp ? in_w : ((model_q.size() != 0) ? model_q[0] : 16'h0);
    chk("count",     32'(count),     32'(model_q.size()));
    chk("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("out",       32'(out_w),     32'(exp_out));
    chk("opcode",    32'(opcode),    32'(exp_out >> 10));
    chk("RA",        32'(ra),        32'((exp_out >> 9) & 16'h1));
    chk("RA_stack",  32'(ra_stack),  32'((exp_out >> 8) & 16'h3));
    chk("BA",        32'(ba),        32'(exp_out & 16'h3FF));
    chk("IMM",       32'(imm),       32'(exp_out & 16'h1FF));
  endtask

  // One clock cycle: apply inputs, check, clock edge, update model.
  task automatic cycle(input logic iv, input logic [15:0] w, input logic ordy, input logic fl);
    logic pop_m, push_m;
    in_valid  = iv;
    in_w      = w;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    pop_m  = exp_ov && ordy;
    push_m = iv && (model_q.size() != DEPTH);
    @(posedge clk);
    if (fl) model_q.delete();
    else if (!(exp_byp && pop_m)) begin
      if (pop_m) void'(model_q.pop_front());
      if (push_m) model_q.push_back(w);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_w = '0; out_ready = 1'b0;
    #1;
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_in_ready", 32'(in_ready),  32'd1);
    chk("rst_out_valid",32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-traffic with three entries queued.
    cycle(1, 16'h1111, 0, 0);
    cycle(1, 16'h2222, 0, 0);
    cycle(1, 16'h3333, 0, 0);
    in_valid = 1'b1; in_w = 16'h4444; out_ready = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    chk("amid_count",     32'(count),     32'd0);
    chk("amid_out_valid", 32'(out_valid), 32'd0);
    chk("amid_out",       32'(out_w),     32'd0);
    chk("amid_in_ready",  32'(in_ready),  32'd1);
    model_q.delete();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Decode of 0xA5C3: opcode 0x29, BA/IMM 0x1C3 (RA/RA_stack from bits 9:8 via model).
    cycle(1, 16'hA5C3, 0, 0);
    in_valid = 1'b0; #1;
    chk("dec_out",    32'(out_w),  32'hA5C3);
    chk("dec_opcode", 32'(opcode), 32'h29);
    chk("dec_BA",     32'(ba),     32'h1C3);
    chk("dec_IMM",    32'(imm),    32'h1C3);
    chk("dec_count",  32'(count),  32'd1);
    cycle(0, 16'h0, 1, 0);

    // Fill to full, reject extra word, drain, then wrap pointers.
    for (int i = 1; i <= 5; i++) cycle(1, 16'(i), 0, 0);
    chk("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0);
    cycle(1, 16'h0006, 0, 0);
    cycle(1, 16'h0007, 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 0, 0);

    // Simultaneous push and pop at count 2.
    cycle(1, 16'hAAAA, 0, 0);
    cycle(1, 16'hBBBB, 0, 0);
    cycle(1, 16'h1234, 1, 0);
    chk("sim_count", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) cycle(0, 16'h0, 1, 0);

    // Flush beats same-cycle push and pop.
    for (int i = 0; i < 3; i++) cycle(1, 16'(16'hC000 + i), 0, 0);
    cycle(1, 16'hBEEF, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Empty queue, word offered and ready: bypass-dependent behaviour.
    cycle(1, 16'h8001, 1, 0);
`ifdef IR_QUEUE_BYPASS_EN
    chk("byp_count_next", 32'(count), 32'd0);
`else
    chk("nobyp_count_next", 32'(count), 32'd1);
`endif
    cycle(0, 16'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
